// File: rtl/usb_hpi_pkg.sv
// Shared types and constants for the CY7C67200 HPI bus sequencer.
package usb_hpi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    DONE,
    RECOVER
  } hpi_state_e;

  localparam logic [1:0] HPI_REG_DATA    = 2'd0;
  localparam logic [1:0] HPI_REG_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_REG_ADDRESS = 2'd2;
  localparam logic [1:0] HPI_REG_STATUS  = 2'd3;

  localparam int unsigned HPI_SETUP_CYC_DEF   = 1;
  localparam int unsigned HPI_STROBE_CYC_DEF  = 4;
  localparam int unsigned HPI_HOLD_CYC_DEF    = 1;
  localparam int unsigned HPI_RECOVER_CYC_DEF = 2;

endpackage

// File: rtl/usb_hpi_ctrl_if.sv
// Avalon-MM slave bundle between the Qsys interconnect and the HPI sequencer.
interface usb_hpi_avs_if;
  logic [1:0]  avs_address;
  logic        avs_chipselect;
  logic        avs_read;
  logic        avs_write;
  logic [15:0] avs_writedata;
  logic [15:0] avs_readdata;
  logic        avs_waitrequest;

  modport slave (
    input  avs_address, avs_chipselect, avs_read, avs_write, avs_writedata,
    output avs_readdata, avs_waitrequest
  );

  modport master (
    output avs_address, avs_chipselect, avs_read, avs_write, avs_writedata,
    input  avs_readdata, avs_waitrequest
  );
endinterface

// File: rtl/usb_hpi_sync2.sv
// Generic 2-flop synchronizer; only built with USB_HPI_IRQ_EN, the sole user.
`ifdef USB_HPI_IRQ_EN
module usb_hpi_sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule
`endif

// File: rtl/usb_hpi_ctrl.sv
// Avalon-MM to CY7C67200 HPI cycle sequencer; each access is stretched into a timed HPI cycle.
// Optional feature macro: USB_HPI_IRQ_EN adds hpi_int -> synchronized irq.
module usb_hpi_ctrl
  import usb_hpi_pkg::*;
#(
  parameter int unsigned SETUP_CYC   = HPI_SETUP_CYC_DEF,
  parameter int unsigned STROBE_CYC  = HPI_STROBE_CYC_DEF,
  parameter int unsigned HOLD_CYC    = HPI_HOLD_CYC_DEF,
  parameter int unsigned RECOVER_CYC = HPI_RECOVER_CYC_DEF
) (
  input  logic         clk,
  input  logic         reset_n,
  usb_hpi_avs_if.slave avs,
  output logic [1:0]   hpi_addr,
  input  logic [15:0]  hpi_data_in,
  output logic [15:0]  hpi_data_out,
  output logic         hpi_data_oe,
  output logic         hpi_cs_n,
  output logic         hpi_rd_n,
  output logic         hpi_wr_n
`ifdef USB_HPI_IRQ_EN
  ,
  input  logic         hpi_int,
  output logic         irq
`endif
);
  localparam int unsigned STROBE_EFF = (STROBE_CYC == 0) ? 1 : STROBE_CYC;
  localparam int unsigned MAX_A   = (SETUP_CYC > STROBE_EFF) ? SETUP_CYC : STROBE_EFF;
  localparam int unsigned MAX_B   = (HOLD_CYC > RECOVER_CYC) ? HOLD_CYC : RECOVER_CYC;
  localparam int unsigned MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  // Counter is loaded with N-1 on entry so a state lasts exactly N cycles.
  localparam logic [CNT_W-1:0] SETUP_LD   = CNT_W'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] STROBE_LD  = CNT_W'(STROBE_EFF - 1);
  localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] RECOVER_LD = CNT_W'((RECOVER_CYC > 0) ? RECOVER_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  hpi_state_e       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [1:0]       addr_q;
  logic [15:0]      wdata_q;
  logic [15:0]      rdata_q;
  logic             wr_q;
  logic             req;
  logic             active;

  assign req = avs.avs_chipselect & (avs.avs_read | avs.avs_write);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == IDLE && req) begin
        addr_q  <= avs.avs_address;
        wdata_q <= avs.avs_writedata;
        wr_q    <= avs.avs_write;
      end
      if (state == STROBE && cnt == '0 && !wr_q) begin
        rdata_q <= hpi_data_in;
      end
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (req) begin
          if (SETUP_CYC > 0) begin
            state_nx = SETUP;
            cnt_nx   = SETUP_LD;
          end else begin
            state_nx = STROBE;
            cnt_nx   = STROBE_LD;
          end
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_nx = STROBE;
          cnt_nx   = STROBE_LD;
        end else begin
          cnt_nx = cnt - CNT_ONE;
        end
      end
      STROBE: begin
        if (cnt == '0) begin
          if (HOLD_CYC > 0) begin
            state_nx = HOLD;
            cnt_nx   = HOLD_LD;
          end else begin
            state_nx = DONE;
          end
        end else begin
          cnt_nx = cnt - CNT_ONE;
        end
      end
      HOLD: begin
        if (cnt == '0) state_nx = DONE;
        else           cnt_nx   = cnt - CNT_ONE;
      end
      DONE: begin
        if (RECOVER_CYC > 0) begin
          state_nx = RECOVER;
          cnt_nx   = RECOVER_LD;
        end else begin
          state_nx = IDLE;
        end
      end
      RECOVER: begin
        if (cnt == '0) state_nx = IDLE;
        else           cnt_nx   = cnt - CNT_ONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Pin decode straight from the async-reset state so reset releases strobes immediately.
  assign active       = (state == SETUP) || (state == STROBE) || (state == HOLD);
  assign hpi_cs_n     = ~active;
  assign hpi_rd_n     = ~((state == STROBE) && !wr_q);
  assign hpi_wr_n     = ~((state == STROBE) && wr_q);
  assign hpi_data_oe  = active & wr_q;
  assign hpi_addr     = active ? addr_q : '0;
  assign hpi_data_out = wdata_q;

  assign avs.avs_readdata    = rdata_q;
  assign avs.avs_waitrequest = req & (state != DONE);

`ifdef USB_HPI_IRQ_EN
  usb_hpi_sync2 #(.WIDTH(1)) u_irq_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (hpi_int),
    .q       (irq)
  );
`endif
endmodule

// File: tb/tb_usb_hpi_ctrl.sv
// Randomized bench for usb_hpi_ctrl: two timing configurations checked against a cycle-timeline model.
module tb_usb_hpi_ctrl;
  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  usb_hpi_avs_if bus0 ();
  usb_hpi_avs_if bus1 ();

  logic [1:0]  p_addr [2];
  logic [15:0] din    [2];
  logic [15:0] p_dout [2];
  logic        p_oe   [2];
  logic        p_cs_n [2];
  logic        p_rd_n [2];
  logic        p_wr_n [2];
`ifdef USB_HPI_IRQ_EN
  logic        p_int  [2];
  logic        p_irq  [2];
`endif

  // Timing of each DUT: setup, strobe, hold, recover
  int ps [2] = '{1, 0};
  int pt [2] = '{4, 1};
  int ph [2] = '{1, 0};
  int pr [2] = '{2, 1};

  int          done_cyc [2];
  logic [15:0] last_rd  [2];

  usb_hpi_ctrl #(.SETUP_CYC(1), .STROBE_CYC(4), .HOLD_CYC(1), .RECOVER_CYC(2)) dut0 (
    .clk(clk), .reset_n(reset_n), .avs(bus0),
    .hpi_addr(p_addr[0]), .hpi_data_in(din[0]), .hpi_data_out(p_dout[0]),
    .hpi_data_oe(p_oe[0]), .hpi_cs_n(p_cs_n[0]), .hpi_rd_n(p_rd_n[0]), .hpi_wr_n(p_wr_n[0])
`ifdef USB_HPI_IRQ_EN
    , .hpi_int(p_int[0]), .irq(p_irq[0])
`endif
  );

  usb_hpi_ctrl #(.SETUP_CYC(0), .STROBE_CYC(1), .HOLD_CYC(0), .RECOVER_CYC(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .avs(bus1),
    .hpi_addr(p_addr[1]), .hpi_data_in(din[1]), .hpi_data_out(p_dout[1]),
    .hpi_data_oe(p_oe[1]), .hpi_cs_n(p_cs_n[1]), .hpi_rd_n(p_rd_n[1]), .hpi_wr_n(p_wr_n[1])
`ifdef USB_HPI_IRQ_EN
    , .hpi_int(p_int[1]), .irq(p_irq[1])
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive(input int d, input bit req, input bit rd, input bit wr,
                       input logic [1:0] a, input logic [15:0] wd);
    if (d == 0) begin
      bus0.avs_chipselect = req; bus0.avs_read = req & rd; bus0.avs_write = req & wr;
      bus0.avs_address = a; bus0.avs_writedata = wd;
    end else begin
      bus1.avs_chipselect = req; bus1.avs_read = req & rd; bus1.avs_write = req & wr;
      bus1.avs_address = a; bus1.avs_writedata = wd;
    end
  endtask

  function automatic logic get_wait(input int d);
    return (d == 0) ? bus0.avs_waitrequest : bus1.avs_waitrequest;
  endfunction

  function automatic logic [15:0] get_rdata(input int d);
    return (d == 0) ? bus0.avs_readdata : bus1.avs_readdata;
  endfunction

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      drive(0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0);
      drive(1, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        check_eq("idle_wait", 32'(get_wait(d)), 32'd0);
        check_eq("idle_cs_n", 32'(p_cs_n[d]), 32'd1);
        check_eq("idle_rd_wr_n", 32'({p_rd_n[d], p_wr_n[d]}), 32'd3);
      end
    end
  endtask

  // One access on DUT d. A request arriving during recovery stalls until recovery
  // has run its full length; then cs_n falls one cycle after IDLE sees the request.
  task automatic access(input int d, input bit rd, input bit wr, input logic [1:0] a,
                        input logic [15:0] wd, input bit rnd_din, input logic [15:0] din_fix);
    int gap, pre, done_k, j, s, t, h;
    bit in_cs, in_st;
    logic [15:0] cap;
    s = ps[d]; t = pt[d]; h = ph[d];
    cap = last_rd[d];
    @(posedge clk); #1;
    gap = cyc - done_cyc[d] - 1;
    pre = (pr[d] > gap) ? pr[d] - gap : 0;
    done_k = pre + 1 + s + t + h;
    for (int k = 0; k <= done_k; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      drive(d, 1'b1, rd, wr, a, wd);
      drive(1 - d, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0);
      din[d] = rnd_din ? 16'($urandom) : din_fix;
      @(negedge clk);
      if (k < pre) begin
        check_eq("stall_wait", 32'(get_wait(d)), 32'd1);
        check_eq("stall_cs_n", 32'(p_cs_n[d]), 32'd1);
      end else begin
        j = k - pre;
        in_cs = (j >= 1) && (j <= s + t + h);
        in_st = (j >= s + 1) && (j <= s + t);
        check_eq("wait", 32'(get_wait(d)), (k == done_k) ? 32'd0 : 32'd1);
        check_eq("cs_n", 32'(p_cs_n[d]), 32'(!in_cs));
        check_eq("wr_n", 32'(p_wr_n[d]), 32'(!(in_st && wr)));
        check_eq("rd_n", 32'(p_rd_n[d]), 32'(!(in_st && !wr)));
        check_eq("data_oe", 32'(p_oe[d]), 32'(in_cs && wr));
        if (in_cs) check_eq("hpi_addr", 32'(p_addr[d]), 32'(a));
        if (in_cs && wr) check_eq("data_out", 32'(p_dout[d]), 32'(wd));
        if (!wr && j == s + t) cap = din[d];
        if (k == done_k) check_eq("readdata", 32'(get_rdata(d)), 32'(cap));
      end
    end
    last_rd[d]  = cap;
    done_cyc[d] = cyc;
  endtask

  initial begin
    int d, op, gap;
    drive(0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0);
    drive(1, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0);
    din[0] = '0; din[1] = '0;
`ifdef USB_HPI_IRQ_EN
    p_int[0] = 1'b0; p_int[1] = 1'b0;
`endif
    for (int i = 0; i < 2; i++) begin done_cyc[i] = -100; last_rd[i] = '0; end
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    for (int i = 0; i < 2; i++) begin
      check_eq("rst_strobes", 32'({p_cs_n[i], p_rd_n[i], p_wr_n[i]}), 32'd7);
      check_eq("rst_oe", 32'(p_oe[i]), 32'd0);
      check_eq("rst_addr", 32'(p_addr[i]), 32'd0);
      check_eq("rst_dout", 32'(p_dout[i]), 32'd0);
      check_eq("rst_rdata", 32'(get_rdata(i)), 32'd0);
    end
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    idle(2);

    access(0, 1'b0, 1'b1, 2'd2, 16'h1234, 1'b0, 16'h0000);
    idle(3);
    access(0, 1'b1, 1'b0, 2'd0, 16'h0000, 1'b0, 16'hBEEF);
    check_eq("read_beef", 32'(get_rdata(0)), 32'h0000BEEF);
    access(0, 1'b0, 1'b1, 2'd1, 16'hAAAA, 1'b1, 16'h0000);
    access(0, 1'b0, 1'b1, 2'd3, 16'h5555, 1'b1, 16'h0000);
    access(1, 1'b0, 1'b1, 2'd1, 16'hC0DE, 1'b1, 16'h0000);
    access(1, 1'b1, 1'b0, 2'd3, 16'h0000, 1'b0, 16'h7E57);
    idle(3);

    // Reset asserted while dut0 is mid-STROBE of a write
    @(posedge clk); #1 drive(0, 1'b1, 1'b0, 1'b1, 2'd1, 16'hA5A5);
    repeat (3) @(posedge clk);
    #2;
    check_eq("pre_rst_wr_n", 32'(p_wr_n[0]), 32'd0);
    reset_n = 1'b0;
    #1;
    check_eq("arst_wr_n", 32'(p_wr_n[0]), 32'd1);
    check_eq("arst_cs_n", 32'(p_cs_n[0]), 32'd1);
    check_eq("arst_oe", 32'(p_oe[0]), 32'd0);
    drive(0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0);
    @(negedge clk) reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin done_cyc[i] = -100; last_rd[i] = '0; end
    idle(6);
    check_eq("post_rst_rdata", 32'(get_rdata(0)), 32'd0);

    for (int i = 0; i < 60; i++) begin
      d   = int'($urandom_range(0, 1));
      op  = int'($urandom_range(0, 2));
      gap = int'($urandom_range(0, 3));
      if (gap > 0) idle(gap);
      access(d, op != 1, op != 0, 2'($urandom_range(0, 3)), 16'($urandom), 1'b1, 16'h0000);
    end
    idle(4);

`ifdef USB_HPI_IRQ_EN
    check_eq("irq_idle", 32'({p_irq[0], p_irq[1]}), 32'd0);
    @(posedge clk); #1 p_int[0] = 1'b1; p_int[1] = 1'b1;
    @(negedge clk) check_eq("irq_lag0", 32'({p_irq[0], p_irq[1]}), 32'd0);
    @(negedge clk) check_eq("irq_lag1", 32'({p_irq[0], p_irq[1]}), 32'd0);
    @(negedge clk) check_eq("irq_rise", 32'({p_irq[0], p_irq[1]}), 32'd3);
    @(posedge clk); #1 p_int[0] = 1'b0; p_int[1] = 1'b0;
    @(negedge clk) check_eq("irq_hold", 32'({p_irq[0], p_irq[1]}), 32'd3);
    @(negedge clk) check_eq("irq_hold1", 32'({p_irq[0], p_irq[1]}), 32'd3);
    @(negedge clk) check_eq("irq_fall", 32'({p_irq[0], p_irq[1]}), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
